fold_sig_accum: RTL and testbench

//  Downstream consumer of the 16-bit XOR fold stage. Accepts one folded pair
//  (aa, bb, 8 bits each) per handshake beat and compacts each stream into an
//  8-bit rotate-XOR signature over a block of WORDS beats. Presents the

---
 rtl/fold_sig_accum.sv | 140 ++++++++++++++
 tb/tb_fold_sig_accum.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fold_sig_accum.sv
// fold_sig_accum: compacts the folded a/b byte streams into a pair of
// rotate-XOR signatures over blocks of WORDS beats, then holds the pair on a
// valid/ready output port until the downstream consumer takes it.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   upstream beat valid
//   in_ready   high while accumulating (ACCUM state)
//   aa, bb     folded a/b stream bytes (W bits)
//   flush      close the current block early (ignored while holding)
//   sig_valid  signature pair available (HOLD state)
//   sig_ready  downstream accepts the signature (ignored while accumulating)
//   sig_aa     a-stream signature
//   sig_bb     b-stream signature
//   sig_cnt    number of beats folded into the signature
//   sig_par    {^sig_bb, ^sig_aa}, present only when FOLD_SIG_PARITY_EN is defined
//
// Optional feature macro: FOLD_SIG_PARITY_EN.

module fold_sig_accum #(
   parameter int unsigned W     = 8,
   parameter int unsigned WORDS = 16,
   localparam int unsigned CW   = $clog2(WORDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  aa,
   input  logic [W-1:0]  bb,
   input  logic          flush,
   output logic          sig_valid,
   input  logic          sig_ready,
   output logic [W-1:0]  sig_aa,
   output logic [W-1:0]  sig_bb,
`ifdef FOLD_SIG_PARITY_EN
   output logic [1:0]    sig_par,
`endif
   output logic [CW-1:0] sig_cnt
);

   typedef enum logic [0:0] {StAccum, StHold} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  acc_aa_q, acc_aa_d;
   logic [W-1:0]  acc_bb_q, acc_bb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  sig_aa_q, sig_aa_d;
   logic [W-1:0]  sig_bb_q, sig_bb_d;
   logic [CW-1:0] sig_cnt_q, sig_cnt_d;
`ifdef FOLD_SIG_PARITY_EN
   logic [1:0]    sig_par_q, sig_par_d;
`endif
   logic          beat;
   logic [W-1:0]  rot_aa, rot_bb;

   assign rot_aa = {acc_aa_q[W-2:0], acc_aa_q[W-1]} ^ aa;
   assign rot_bb = {acc_bb_q[W-2:0], acc_bb_q[W-1]} ^ bb;

   always_comb begin
      state_d   = state_q;
      acc_aa_d  = acc_aa_q;
      acc_bb_d  = acc_bb_q;
      cnt_d     = cnt_q;
      sig_aa_d  = sig_aa_q;
      sig_bb_d  = sig_bb_q;
      sig_cnt_d = sig_cnt_q;
`ifdef FOLD_SIG_PARITY_EN
      sig_par_d = sig_par_q;
`endif
      beat      = in_valid && (state_q == StAccum);

      unique case (state_q)
         StAccum: begin
            if (beat) begin
               acc_aa_d = rot_aa;
               acc_bb_d = rot_bb;
               cnt_d    = cnt_q + CW'(1);
            end
            // Close on the beat that completes the block, or on flush; a beat
            // in the flush cycle is already folded into acc_*_d.
            if (flush || (beat && (cnt_q == CW'(WORDS - 1)))) begin
               state_d   = StHold;
               sig_aa_d  = acc_aa_d;
               sig_bb_d  = acc_bb_d;
               sig_cnt_d = cnt_d;
`ifdef FOLD_SIG_PARITY_EN
               sig_par_d = {^acc_bb_d, ^acc_aa_d};
`endif
            end
         end
         StHold: begin
            if (sig_ready) begin
               state_d  = StAccum;
               acc_aa_d = '0;
               acc_bb_d = '0;
               cnt_d    = '0;
            end
         end
         default: state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StAccum;
         acc_aa_q  <= '0;
         acc_bb_q  <= '0;
         cnt_q     <= '0;
         sig_aa_q  <= '0;
         sig_bb_q  <= '0;
         sig_cnt_q <= '0;
`ifdef FOLD_SIG_PARITY_EN
         sig_par_q <= '0;
`endif
      end else begin
         state_q   <= state_d;
         acc_aa_q  <= acc_aa_d;
         acc_bb_q  <= acc_bb_d;
         cnt_q     <= cnt_d;
         sig_aa_q  <= sig_aa_d;
         sig_bb_q  <= sig_bb_d;
         sig_cnt_q <= sig_cnt_d;
`ifdef FOLD_SIG_PARITY_EN
         sig_par_q <= sig_par_d;
`endif
      end
   end

   assign in_ready  = (state_q == StAccum);
   assign sig_valid = (state_q == StHold);
   assign sig_aa    = sig_aa_q;
   assign sig_bb    = sig_bb_q;
   assign sig_cnt   = sig_cnt_q;
`ifdef FOLD_SIG_PARITY_EN
   assign sig_par   = sig_par_q;
`endif

endmodule

// File: tb/tb_fold_sig_accum.sv
// Testbench for fold_sig_accum (WORDS=4). Directed scenarios plus a randomized
// run against a block-level reference model (list of accepted beats per block,
// signature computed arithmetically when the block closes).

module tb_fold_sig_accum;

   localparam int unsigned W     = 8;
   localparam int unsigned WORDS = 4;
   localparam int unsigned CW    = $clog2(WORDS + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  aa;
   logic [W-1:0]  bb;
   logic          flush;
   logic          sig_valid;
   logic          sig_ready;
   logic [W-1:0]  sig_aa;
   logic [W-1:0]  sig_bb;
   logic [CW-1:0] sig_cnt;
`ifdef FOLD_SIG_PARITY_EN
   logic [1:0]    sig_par;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fold_sig_accum #(.W(W), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aa        (aa),
      .bb        (bb),
      .flush     (flush),
      .sig_valid (sig_valid),
      .sig_ready (sig_ready),
      .sig_aa    (sig_aa),
      .sig_bb    (sig_bb),
`ifdef FOLD_SIG_PARITY_EN
      .sig_par   (sig_par),
`endif
      .sig_cnt   (sig_cnt)
   );

   // ---------------- reference model ----------------
   int unsigned blk_aa[$];
   int unsigned blk_bb[$];
   bit          m_hold;
   int unsigned exp_aa, exp_bb, exp_cnt;
   int          blocks_done;

   function automatic int unsigned sig_of(input int unsigned beats[$]);
      int unsigned s = 0;
      foreach (beats[i]) s = (((s * 2) % 256) + (s / 128)) ^ beats[i];
      return s;
   endfunction

   function automatic int unsigned par8(input int unsigned v);
      int unsigned p = 0;
      for (int i = 0; i < 8; i++) p ^= (v >> i) & 1;
      return p;
   endfunction

   // Advance the model with the inputs present before the edge, then clock.
   task automatic cycle();
      if (rst) begin
         m_hold = 0;
         blk_aa.delete();
         blk_bb.delete();
         exp_aa = 0; exp_bb = 0; exp_cnt = 0;
      end else if (!m_hold) begin
         if (in_valid) begin
            blk_aa.push_back(aa);
            blk_bb.push_back(bb);
         end
         if (flush || blk_aa.size() == WORDS) begin
            m_hold  = 1;
            exp_aa  = sig_of(blk_aa);
            exp_bb  = sig_of(blk_bb);
            exp_cnt = blk_aa.size();
            blk_aa.delete();
            blk_bb.delete();
         end
      end else if (sig_ready) begin
         m_hold = 0;
         blocks_done++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic f, input logic r);
      in_valid = v; aa = a; bb = b; flush = f; sig_ready = r;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(0, 8'h00, 8'h00, 0, 0);
      cycle(); cycle();
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (sig_valid !== 1'b0) begin errors++;
         $display("FAIL reset_sig_valid got %b want 0", sig_valid); end
      checks++; if (sig_aa !== 8'h00 || sig_bb !== 8'h00 || sig_cnt !== 3'd0) begin errors++;
         $display("FAIL reset_sig got %h/%h/%0d want 00/00/0", sig_aa, sig_bb, sig_cnt); end
`ifdef FOLD_SIG_PARITY_EN
      checks++; if (sig_par !== 2'b00) begin errors++;
         $display("FAIL reset_sig_par got %b want 00", sig_par); end
`endif
   endtask

   task automatic test_full_block();
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'h01, 8'h80, 0, 1);
         cycle();
         if (i == 2) begin
            checks++; if (sig_valid !== 1'b0) begin errors++;
               $display("FAIL full_early_valid got %b want 0", sig_valid); end
         end
      end
      drive(0, 8'h00, 8'h00, 0, 1);
      checks++; if (sig_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
         $display("FAIL full_valid got v=%b r=%b want v=1 r=0", sig_valid, in_ready); end
      checks++; if (sig_aa !== 8'h0F || sig_bb !== 8'h87 || sig_cnt !== 3'd4) begin errors++;
         $display("FAIL full_sig got %h/%h/%0d want 0f/87/4", sig_aa, sig_bb, sig_cnt); end
`ifdef FOLD_SIG_PARITY_EN
      checks++; if (sig_par !== 2'b00) begin errors++;
         $display("FAIL full_sig_par got %b want 00", sig_par); end
`endif
      cycle();
      checks++; if (in_ready !== 1'b1 || sig_valid !== 1'b0) begin errors++;
         $display("FAIL full_release got r=%b v=%b want r=1 v=0", in_ready, sig_valid); end
   endtask

   task automatic test_flush_partial();
      drive(1, 8'h01, 8'h00, 0, 0);
      cycle();
      drive(1, 8'h01, 8'h00, 1, 0);
      cycle();
      drive(0, 8'h00, 8'h00, 0, 0);
      checks++; if (sig_valid !== 1'b1 || sig_aa !== 8'h03 || sig_cnt !== 3'd2) begin errors++;
         $display("FAIL flush_partial got v=%b %h/%0d want v=1 03/2", sig_valid, sig_aa, sig_cnt);
      end
      drive(0, 8'h00, 8'h00, 0, 1);
      cycle();
   endtask

   task automatic test_hold_stall();
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'($urandom), 8'($urandom), 0, 0);
         cycle();
      end
      for (int i = 0; i < 10; i++) begin
         // Beats and flush offered while holding must be ignored.
         drive(1, 8'($urandom), 8'($urandom), 1'(i % 2), 0);
         cycle();
         checks++; if (in_ready !== 1'b0 || sig_valid !== 1'b1) begin errors++;
            $display("FAIL stall_hs cyc %0d got r=%b v=%b want r=0 v=1", i, in_ready, sig_valid);
         end
         checks++;
         if (sig_aa !== 8'(exp_aa) || sig_bb !== 8'(exp_bb) || sig_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL stall_sig cyc %0d got %h/%h/%0d want %h/%h/%0d", i, sig_aa, sig_bb,
                     sig_cnt, exp_aa[7:0], exp_bb[7:0], exp_cnt);
         end
      end
      drive(0, 8'h00, 8'h00, 0, 1);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'h01, 8'h00, 0, 0);
         cycle();
      end
      checks++; if (sig_valid !== 1'b1 || sig_aa !== 8'h0F || sig_cnt !== 3'd4) begin errors++;
         $display("FAIL stall_next got v=%b %h/%0d want v=1 0f/4", sig_valid, sig_aa, sig_cnt);
      end
      drive(0, 8'h00, 8'h00, 0, 1);
      cycle();
   endtask

   task automatic test_empty_flush();
      drive(0, 8'h55, 8'hAA, 1, 0);
      cycle();
      drive(0, 8'h00, 8'h00, 0, 0);
      checks++;
      if (sig_valid !== 1'b1 || sig_aa !== 8'h00 || sig_bb !== 8'h00 || sig_cnt !== 3'd0) begin
         errors++;
         $display("FAIL empty_flush got v=%b %h/%h/%0d want v=1 00/00/0", sig_valid, sig_aa,
                  sig_bb, sig_cnt);
      end
      drive(0, 8'h00, 8'h00, 0, 1);
      cycle();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         drive(1, 8'h5A, 8'hC3, 0, 0);
         cycle();
      end
      drive(0, 8'h00, 8'h00, 0, 0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++; if (in_ready !== 1'b1 || sig_valid !== 1'b0 || sig_aa !== 8'h00 ||
                    sig_bb !== 8'h00 || sig_cnt !== 3'd0) begin errors++;
         $display("FAIL reset_mid got r=%b v=%b %h/%h/%0d want r=1 v=0 00/00/0", in_ready,
                  sig_valid, sig_aa, sig_bb, sig_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 8'h01, 8'h00, 0, 0);
         cycle();
      end
      checks++; if (sig_valid !== 1'b1 || sig_aa !== 8'h0F || sig_cnt !== 3'd4) begin errors++;
         $display("FAIL reset_mid_next got v=%b %h/%0d want v=1 0f/4", sig_valid, sig_aa, sig_cnt);
      end
      drive(0, 8'h00, 8'h00, 0, 1);
      cycle();
   endtask

   task automatic test_random();
      int cyc = 0;
      blocks_done = 0;
      while (blocks_done < 1000 && cyc < 40000) begin
         drive(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
         cycle();
         cyc++;
         checks++; if (in_ready !== !m_hold || sig_valid !== m_hold) begin errors++;
            $display("FAIL rand_hs cyc %0d got r=%b v=%b want hold=%b", cyc, in_ready,
                     sig_valid, m_hold);
         end
         checks++;
         if (sig_aa !== 8'(exp_aa) || sig_bb !== 8'(exp_bb) || sig_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL rand_sig cyc %0d got %h/%h/%0d want %h/%h/%0d", cyc, sig_aa, sig_bb,
                     sig_cnt, exp_aa[7:0], exp_bb[7:0], exp_cnt);
         end
`ifdef FOLD_SIG_PARITY_EN
         checks++; if (sig_par !== {1'(par8(exp_bb)), 1'(par8(exp_aa))}) begin errors++;
            $display("FAIL rand_par cyc %0d got %b", cyc, sig_par);
         end
`endif
      end
      checks++; if (blocks_done < 1000) begin errors++;
         $display("FAIL rand_timeout blocks %0d want 1000", blocks_done);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 8'h00, 8'h00, 0, 0);
      test_reset();
      test_full_block();
      test_flush_partial();
      test_hold_stall();
      test_empty_flush();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
